// File: rtl/round_ctrl_pkg.sv
// Shared definitions for the poker round controller: state codes, rank codes,
// the default minimum bet and the payout multiplier constants.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAL   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DRAW   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_PAYOUT = 3'd5,
    ST_BROKE  = 3'd6
  } state_t;

  localparam logic [3:0] RANK_LOSE           = 4'd0;
  localparam logic [3:0] RANK_TWO_PAIR       = 4'd1;
  localparam logic [3:0] RANK_THREE_KIND     = 4'd2;
  localparam logic [3:0] RANK_STRAIGHT       = 4'd3;
  localparam logic [3:0] RANK_FLUSH          = 4'd4;
  localparam logic [3:0] RANK_FULL_HOUSE     = 4'd5;
  localparam logic [3:0] RANK_FOUR_KIND      = 4'd6;
  localparam logic [3:0] RANK_STRAIGHT_FLUSH = 4'd7;
  localparam logic [3:0] RANK_FIVE_KIND      = 4'd8;
  localparam logic [3:0] RANK_ROYAL          = 4'd9;

  localparam logic [15:0] MIN_BET_DEFAULT = 16'd10;

  localparam logic [7:0] MULT_LOSE           = 8'd0;
  localparam logic [7:0] MULT_TWO_PAIR       = 8'd1;
  localparam logic [7:0] MULT_THREE_KIND     = 8'd1;
  localparam logic [7:0] MULT_STRAIGHT       = 8'd3;
  localparam logic [7:0] MULT_FLUSH          = 8'd4;
  localparam logic [7:0] MULT_FULL_HOUSE     = 8'd10;
  localparam logic [7:0] MULT_FOUR_KIND      = 8'd20;
  localparam logic [7:0] MULT_STRAIGHT_FLUSH = 8'd25;
  localparam logic [7:0] MULT_FIVE_KIND      = 8'd40;
  localparam logic [7:0] MULT_ROYAL          = 8'd250;

endpackage

// File: rtl/round_ctrl_pay_table.sv
// Combinational payout multiplier lookup: hand rank in, 8-bit multiplier out.
module poker_pay_table
  import round_ctrl_pkg::*;
(
  input  logic [3:0] rank,
  output logic [7:0] mult
);

  // Map each rank code to its multiplier; unused codes pay nothing.
  always_comb begin
    case (rank)
      RANK_LOSE:           mult = MULT_LOSE;
      RANK_TWO_PAIR:       mult = MULT_TWO_PAIR;
      RANK_THREE_KIND:     mult = MULT_THREE_KIND;
      RANK_STRAIGHT:       mult = MULT_STRAIGHT;
      RANK_FLUSH:          mult = MULT_FLUSH;
      RANK_FULL_HOUSE:     mult = MULT_FULL_HOUSE;
      RANK_FOUR_KIND:      mult = MULT_FOUR_KIND;
      RANK_STRAIGHT_FLUSH: mult = MULT_STRAIGHT_FLUSH;
      RANK_FIVE_KIND:      mult = MULT_FIVE_KIND;
      RANK_ROYAL:          mult = MULT_ROYAL;
      default:             mult = MULT_LOSE;
    endcase
  end

endmodule

// File: rtl/round_ctrl.sv
// Round controller for a video-poker machine: sequences deal/hold/draw/eval,
// debits the wager at the start of a hand and credits the saturated payout.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter logic [15:0] START_MONEY = 16'd1000,
  parameter logic [15:0] MIN_BET     = MIN_BET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_c,
  input  logic        start_p,
  input  logic        hold_done_p,
  input  logic        rank_valid,
  input  logic [3:0]  rank,
  input  logic [15:0] wager_i,
  output logic        bet_s,
  output logic [15:0] money_r,
  output logic        deal_req,
  output logic        draw_req,
  output logic        eval_req,
  output logic [15:0] payout_o,
  output logic [2:0]  state_o,
  output logic        broke_o
);

  state_t      state_q, state_d;
  logic [15:0] wager_l, wager_d;
  logic [15:0] money_d, payout_d;
  logic [15:0] wager_eff;
  logic [7:0]  mult;
  logic [23:0] prod;
  logic [15:0] pay_sat;
  logic [16:0] sum;
  logic [15:0] money_sat;

  poker_pay_table u_pay_table (
    .rank (rank),
    .mult (mult)
  );

  // Wager is capped at the balance; product and sum saturate at 16 bits.
  assign wager_eff = (wager_i < money_r) ? wager_i : money_r;
  assign prod      = 24'(wager_l) * 24'(mult);
  assign pay_sat   = (prod > 24'h00FFFF) ? 16'hFFFF : prod[15:0];
  assign sum       = 17'(money_r) + 17'(pay_sat);
  assign money_sat = sum[16] ? 16'hFFFF : sum[15:0];
  assign state_o   = state_q;

  // Next-state and next-value logic for the hand sequence.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    money_d  = money_r;
    payout_d = payout_o;
    wager_d  = wager_l;
    case (state_q)
      ST_IDLE: begin
        if (start_p && (wager_i >= MIN_BET)) begin
          wager_d = wager_eff;
          money_d = money_r - wager_eff;
          state_d = ST_DEAL;
        end
      end
      ST_DEAL: state_d = ST_HOLD;
      ST_HOLD: if (hold_done_p) state_d = ST_DRAW;
      ST_DRAW: state_d = ST_EVAL;
      ST_EVAL: begin
        if (rank_valid) begin
          payout_d = pay_sat;
          money_d  = money_sat;
          state_d  = ST_PAYOUT;
        end
      end
      ST_PAYOUT: state_d = (money_r < MIN_BET) ? ST_BROKE : ST_IDLE;
      ST_BROKE:  state_d = ST_BROKE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, balance and registered outputs; pulses are decoded from the next state.
  // NOTE: asynchronous reset in the sensitivity list, and non-blocking assignments
  // so every register samples the pre-edge values.
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state_q  <= ST_IDLE;
      money_r  <= START_MONEY;
      payout_o <= 16'd0;
      wager_l  <= 16'd0;
      deal_req <= 1'b0;
      draw_req <= 1'b0;
      eval_req <= 1'b0;
      broke_o  <= 1'b0;
      bet_s    <= 1'b1;
    end else begin
      state_q  <= state_d;
      money_r  <= money_d;
      payout_o <= payout_d;
      wager_l  <= wager_d;
      deal_req <= (state_d == ST_DEAL);
      draw_req <= (state_d == ST_DRAW);
      eval_req <= (state_d == ST_EVAL) && (state_q != ST_EVAL);
      broke_o  <= (state_d == ST_BROKE);
      bet_s    <= (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: a per-cycle reference model of the hand
// rules, a compare process on the falling edge, and directed hands with
// hand-computed expectations.
module tb_round_ctrl;

  logic        clock;
  logic        reset_c;
  logic        start_p, hold_done_p, rank_valid;
  logic [3:0]  rank;
  logic [15:0] wager_i;
  logic        bet_s, deal_req, draw_req, eval_req, broke_o;
  logic [15:0] money_r, payout_o;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  round_ctrl dut (
    .clock       (clock),
    .reset_c     (reset_c),
    .start_p     (start_p),
    .hold_done_p (hold_done_p),
    .rank_valid  (rank_valid),
    .rank        (rank),
    .wager_i     (wager_i),
    .bet_s       (bet_s),
    .money_r     (money_r),
    .deal_req    (deal_req),
    .draw_req    (draw_req),
    .eval_req    (eval_req),
    .payout_o    (payout_o),
    .state_o     (state_o),
    .broke_o     (broke_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase names, integer balance, table-driven multipliers.
  localparam int P_IDLE = 0, P_DEAL = 1, P_HOLD = 2, P_DRAW = 3,
                 P_EVAL = 4, P_PAYOUT = 5, P_BROKE = 6;
  localparam int MINB = 10;
  int mult_tab [16] = '{0, 1, 1, 3, 4, 10, 20, 25, 40, 250, 0, 0, 0, 0, 0, 0};
  int m_phase, m_money, m_payout, m_wager;
  bit m_first_eval;

  function automatic int sat16(input longint v);
    return (v > 65535) ? 65535 : int'(v);
  endfunction

  always @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      m_phase      <= P_IDLE;
      m_money      <= 1000;
      m_payout     <= 0;
      m_wager      <= 0;
      m_first_eval <= 1'b0;
    end else begin
      m_first_eval <= 1'b0;
      if (m_phase == P_IDLE && start_p && int'(wager_i) >= MINB) begin
        m_wager <= (int'(wager_i) < m_money) ? int'(wager_i) : m_money;
        m_money <= m_money - ((int'(wager_i) < m_money) ? int'(wager_i) : m_money);
        m_phase <= P_DEAL;
      end else if (m_phase == P_DEAL) begin
        m_phase <= P_HOLD;
      end else if (m_phase == P_HOLD && hold_done_p) begin
        m_phase <= P_DRAW;
      end else if (m_phase == P_DRAW) begin
        m_phase      <= P_EVAL;
        m_first_eval <= 1'b1;
      end else if (m_phase == P_EVAL && rank_valid) begin
        m_payout <= sat16(longint'(m_wager) * mult_tab[rank]);
        m_money  <= sat16(longint'(m_money) + sat16(longint'(m_wager) * mult_tab[rank]));
        m_phase  <= P_PAYOUT;
      end else if (m_phase == P_PAYOUT) begin
        m_phase <= (m_money < MINB) ? P_BROKE : P_IDLE;
      end
    end
  end

  // Compare every output against the model away from the rising edge.
  always @(negedge clock) begin
    if (reset_c) begin
      check("state_o",  int'(state_o),  m_phase);
      check("money_r",  int'(money_r),  m_money);
      check("payout_o", int'(payout_o), m_payout);
      check("bet_s",    int'(bet_s),    int'(m_phase == P_IDLE));
      check("broke_o",  int'(broke_o),  int'(m_phase == P_BROKE));
      check("deal_req", int'(deal_req), int'(m_phase == P_DEAL));
      check("draw_req", int'(draw_req), int'(m_phase == P_DRAW));
      check("eval_req", int'(eval_req), int'(m_phase == P_EVAL && m_first_eval));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_c = 1'b0;
    start_p = 1'b0; hold_done_p = 1'b0; rank_valid = 1'b0;
    rank = 4'd0; wager_i = 16'd0;
    step();
    reset_c = 1'b1;
    step();
  endtask

  // One full hand, lingering an extra cycle in EVAL; ends in IDLE or BROKE.
  task automatic play(input int w, input int r, input int exp_pay, input int exp_money);
    wager_i = 16'(w);
    start_p = 1'b1;
    step();
    start_p = 1'b0;
    check("hand_deal_state", int'(state_o), P_DEAL);
    step();
    hold_done_p = 1'b1;
    step();
    hold_done_p = 1'b0;
    step();
    step();
    check("hand_eval_state", int'(state_o), P_EVAL);
    rank = 4'(r);
    rank_valid = 1'b1;
    step();
    rank_valid = 1'b0;
    check("hand_payout", int'(payout_o), exp_pay);
    check("hand_money",  int'(money_r),  exp_money);
    step();
  endtask

  initial begin
    reset_c = 1'b1;
    #1;
    do_reset();
    check("rst_money",  int'(money_r),  1000);
    check("rst_state",  int'(state_o),  0);
    check("rst_bet_s",  int'(bet_s),    1);
    check("rst_payout", int'(payout_o), 0);
    check("rst_broke",  int'(broke_o),  0);

    // Wager below minimum is ignored.
    wager_i = 16'd5; start_p = 1'b1; step(); start_p = 1'b0;
    check("small_wager_idle", int'(state_o), 0);
    check("small_wager_money", int'(money_r), 1000);

    // Full house on 50: debit shows right after the deal edge.
    wager_i = 16'd50; start_p = 1'b1; step(); start_p = 1'b0;
    check("fh_debit", int'(money_r), 950);
    check("fh_deal_req", int'(deal_req), 1);
    step(); hold_done_p = 1'b1; step(); hold_done_p = 1'b0; step();
    rank = 4'd5; rank_valid = 1'b1; step(); rank_valid = 1'b0;
    check("fh_payout", int'(payout_o), 500);
    check("fh_money", int'(money_r), 1450);
    step();
    check("fh_idle", int'(state_o), 0);

    // Losing hand; start_p and rank_valid during HOLD must be ignored.
    do_reset();
    wager_i = 16'd50; start_p = 1'b1; step(); start_p = 1'b0;
    step();
    start_p = 1'b1; rank = 4'd9; rank_valid = 1'b1; step();
    start_p = 1'b0; rank_valid = 1'b0;
    check("hold_ignore_state", int'(state_o), 2);
    check("hold_ignore_money", int'(money_r), 950);
    hold_done_p = 1'b1; step(); hold_done_p = 1'b0; step();
    rank = 4'd0; rank_valid = 1'b1; step(); rank_valid = 1'b0;
    check("lose_payout", int'(payout_o), 0);
    check("lose_money", int'(money_r), 950);
    step();

    // Several rank codes including an unused one.
    play(40, 3, 120, 1030);
    play(20, 12, 0, 1010);
    play(10, 1, 10, 1010);
    play(25, 7, 625, 1610);

    // Royal flushes drive product and balance into saturation.
    do_reset();
    play(250, 9, 62500, 63250);
    play(10000, 9, 65535, 65535);

    // Bet exceeding balance is capped, leading to BROKE.
    do_reset();
    wager_i = 16'd2000; start_p = 1'b1; step(); start_p = 1'b0;
    check("broke_debit", int'(money_r), 0);
    step(); hold_done_p = 1'b1; step(); hold_done_p = 1'b0; step();
    rank = 4'd0; rank_valid = 1'b1; step(); rank_valid = 1'b0;
    step();
    check("broke_state", int'(state_o), 6);
    check("broke_flag", int'(broke_o), 1);
    check("broke_bet_s", int'(bet_s), 0);
    wager_i = 16'd50; start_p = 1'b1; step(); start_p = 1'b0; step();
    check("broke_stays", int'(state_o), 6);

    // Reset during EVAL abandons the hand immediately.
    do_reset();
    wager_i = 16'd50; start_p = 1'b1; step(); start_p = 1'b0;
    step(); hold_done_p = 1'b1; step(); hold_done_p = 1'b0; step();
    check("pre_rst_eval", int'(state_o), 4);
    reset_c = 1'b0;
    #1;
    check("mid_rst_state", int'(state_o), 0);
    check("mid_rst_money", int'(money_r), 1000);
    check("mid_rst_eval_req", int'(eval_req), 0);
    #1;
    reset_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_eval_req", int'(eval_req), 0);
    end
    check("post_rst_state", int'(state_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
